// File: rtl/ad5681r_spi_tx_if.sv
// ad5681r_spi_tx_if: frame handshake plus AD5681R pin bundle for the SPI transmitter.
interface ad5681r_spi_tx_if;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic        sclk;
   logic        sdo;
   logic        sync_n;
   logic        ldac_n;
   modport master (output in_data, in_valid,
                   input  in_ready, busy, done, sclk, sdo, sync_n, ldac_n);
   modport slave  (input  in_data, in_valid,
                   output in_ready, busy, done, sclk, sdo, sync_n, ldac_n);
endinterface

// File: rtl/ad5681r_spi_tx.sv
// ad5681r_spi_tx: serialises 24-bit AD5681R frames onto SYNC/SCLK/SDIN, then optionally pulses LDAC.
module ad5681r_spi_tx #(
   parameter int CLK_DIV    = 2,
   parameter int SYNC_GAP   = 4,
   parameter int AUTO_LDAC  = 1,
   parameter int LDAC_PULSE = 2
) (
   input logic              clk,
   input logic              rst,
   ad5681r_spi_tx_if.slave  bus
);
   localparam int MAX_A = (CLK_DIV > SYNC_GAP) ? CLK_DIV : SYNC_GAP;
   localparam int MAX_C = (MAX_A > LDAC_PULSE) ? MAX_A : LDAC_PULSE;
   localparam int DW = $clog2(MAX_C + 1);
   localparam logic [DW-1:0] DIV_LD  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_LD  = DW'(SYNC_GAP - 1);
   localparam logic [DW-1:0] LDAC_LD = DW'(LDAC_PULSE - 1);
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, LDAC} state_t;
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shift_q, shift_d;
   logic          sclk_q, sclk_d, sdo_q, sdo_d;
   logic          sync_n_q, ldac_n_q, ready_q, busy_q, done_q;
   logic          zero;
   assign zero = (div_q == '0);
   always_comb begin
      state_d = state_q;
      div_d   = div_q - DW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      sclk_d  = sclk_q;
      sdo_d   = sdo_q;
      case (state_q)
         IDLE: begin
            sclk_d = 1'b1;
            if (bus.in_valid && ready_q) begin
               state_d = LEAD;
               div_d   = DIV_LD;
               bit_d   = '0;
               shift_d = bus.in_data;
               sdo_d   = bus.in_data[23];
            end
         end
         LEAD: if (zero) begin
            state_d = SHIFT;
            div_d   = DIV_LD;
            sclk_d  = 1'b0;
         end
         SHIFT: if (zero) begin
            div_d = DIV_LD;
            // sdo only moves on the rising edge, keeping it stable across the DAC's sampling fall
            if (!sclk_q) begin
               sclk_d  = 1'b1;
               shift_d = {shift_q[22:0], 1'b0};
               sdo_d   = shift_q[22];
            end else if (bit_q == 5'd23) begin
               state_d = GAP;
               div_d   = GAP_LD;
            end else begin
               bit_d  = bit_q + 5'd1;
               sclk_d = 1'b0;
            end
         end
         GAP: if (zero) begin
            state_d = (AUTO_LDAC != 0) ? LDAC : IDLE;
            div_d   = LDAC_LD;
         end
         LDAC: if (zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         sclk_q   <= 1'b1;
         sdo_q    <= 1'b0;
         sync_n_q <= 1'b1;
         ldac_n_q <= 1'b1;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         sclk_q   <= sclk_d;
         sdo_q    <= sdo_d;
         sync_n_q <= !(state_d == LEAD || state_d == SHIFT);
         ldac_n_q <= (state_d != LDAC);
         ready_q  <= (state_d == IDLE);
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_q != IDLE) && (state_d == IDLE);
      end
   end
   assign bus.in_ready = ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sclk     = sclk_q;
   assign bus.sdo      = sdo_q;
   assign bus.sync_n   = sync_n_q;
   assign bus.ldac_n   = ldac_n_q;
endmodule

// File: tb/tb_ad5681r_spi_tx.sv
// tb_ad5681r_spi_tx: directed vectors for the AD5681R SPI transmitter, default and fast/no-LDAC builds.
module tb_ad5681r_spi_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   ad5681r_spi_tx_if ia();
   ad5681r_spi_tx_if ib();
   ad5681r_spi_tx #(.CLK_DIV(2), .SYNC_GAP(4), .AUTO_LDAC(1), .LDAC_PULSE(2))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   ad5681r_spi_tx #(.CLK_DIV(1), .SYNC_GAP(4), .AUTO_LDAC(0), .LDAC_PULSE(2))
      dut_b (.clk(clk), .rst(rst), .bus(ib));
   always #5 clk = ~clk;
   typedef struct {
      logic [23:0] frame;
      int          falls;
      int          low;
      int          high_before;
   } rec_t;
   rec_t        recs[$];
   logic [23:0] sh_a = '0;
   int          falls_a = 0, low_a = 0, high_a = 0, ldac_a = 0;
   int          gap_a = 0, ldac_w_a = 0, done_a = 0, hb_a = 0;
   logic        ps_a = 1'b1, py_a = 1'b1, pl_a = 1'b1;
   always @(negedge clk) begin
      if (rst) begin
         ps_a = 1'b1; py_a = 1'b1; pl_a = 1'b1;
         falls_a = 0; low_a = 0; high_a = 0; ldac_a = 0;
      end else begin
         if (!ia.ldac_n && pl_a) begin gap_a = high_a; ldac_a = 0; end
         if (!ia.ldac_n) ldac_a++;
         if (ia.ldac_n && !pl_a) ldac_w_a = ldac_a;
         if (!ia.sync_n) begin
            if (py_a) begin hb_a = high_a; low_a = 0; end
            low_a++;
            if (ps_a && !ia.sclk) begin sh_a = {sh_a[22:0], ia.sdo}; falls_a++; end
         end else begin
            if (!py_a) begin
               recs.push_back('{sh_a, falls_a, low_a, hb_a});
               falls_a = 0; high_a = 0;
            end
            high_a++;
         end
         if (ia.done) done_a++;
         ps_a = ia.sclk; py_a = ia.sync_n; pl_a = ia.ldac_n;
      end
   end
   logic [23:0] sh_b = '0, frame_b = '0;
   int          falls_b = 0, low_b = 0, falls_last_b = 0, low_last_b = 0;
   int          ldac_low_b = 0, cyc_b = 0, last_fall_b = 0, per_min_b = 1000, per_max_b = 0, done_b = 0;
   logic        ps_b = 1'b1, py_b = 1'b1;
   always @(negedge clk) begin
      if (rst) begin
         ps_b = 1'b1; py_b = 1'b1; falls_b = 0; low_b = 0;
      end else begin
         cyc_b++;
         if (!ib.ldac_n) ldac_low_b++;
         if (ib.done) done_b++;
         if (!ib.sync_n) begin
            if (py_b) low_b = 0;
            low_b++;
            if (ps_b && !ib.sclk) begin
               if (falls_b > 0) begin
                  if (cyc_b - last_fall_b < per_min_b) per_min_b = cyc_b - last_fall_b;
                  if (cyc_b - last_fall_b > per_max_b) per_max_b = cyc_b - last_fall_b;
               end
               last_fall_b = cyc_b;
               sh_b = {sh_b[22:0], ib.sdo};
               falls_b++;
            end
         end else if (!py_b) begin
            frame_b = sh_b; falls_last_b = falls_b; low_last_b = low_b; falls_b = 0;
         end
         ps_b = ib.sclk; py_b = ib.sync_n;
      end
   end
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic send_a(input logic [23:0] d);
      int n = 0;
      while (!ia.in_ready && n < 500) begin tick(); n++; end
      chk("send_ready", int'(ia.in_ready), 1);
      ia.in_data = d;
      ia.in_valid = 1'b1;
      tick();
      ia.in_valid = 1'b0;
   endtask
   task automatic wait_done_a();
      int n = 0;
      while (!ia.done && n < 400) begin tick(); n++; end
      chk("done_seen", int'(ia.done), 1);
   endtask
   typedef struct {
      logic [23:0] data;
      int          exp_falls;
      int          exp_low;
      int          exp_gap;
      int          exp_ldac;
   } vec_t;
   vec_t vecs[5];
   initial begin
      int   nrec, d0, bad, n;
      rec_t r;
      vecs[0] = '{24'h300000, 24, 98, 4, 2};
      vecs[1] = '{24'hA5A5A5, 24, 98, 4, 2};
      vecs[2] = '{24'h000001, 24, 98, 4, 2};
      vecs[3] = '{24'h800000, 24, 98, 4, 2};
      vecs[4] = '{24'hFFFFFF, 24, 98, 4, 2};
      ia.in_data = '0; ia.in_valid = 1'b0;
      ib.in_data = '0; ib.in_valid = 1'b0;
      repeat (3) tick();
      chk("rst_sclk", int'(ia.sclk), 1);
      chk("rst_sdo", int'(ia.sdo), 0);
      chk("rst_sync_n", int'(ia.sync_n), 1);
      chk("rst_ldac_n", int'(ia.ldac_n), 1);
      chk("rst_ready", int'(ia.in_ready), 0);
      chk("rst_busy", int'(ia.busy), 0);
      chk("rst_done", int'(ia.done), 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", int'(ia.in_ready), 1);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (ia.sclk !== 1'b1 || ia.sync_n !== 1'b1 || ia.sdo !== 1'b0 || ia.in_ready !== 1'b1) bad++;
         tick();
      end
      chk("idle_200_bad_cycles", bad, 0);
      for (int i = 0; i < 5; i++) begin
         nrec = recs.size();
         d0 = done_a;
         send_a(vecs[i].data);
         wait_done_a();
         tick();
         chk("vec_nframes", recs.size() - nrec, 1);
         r = recs[recs.size() - 1];
         chk("vec_frame", int'(r.frame), int'(vecs[i].data));
         chk("vec_falls", r.falls, vecs[i].exp_falls);
         chk("vec_sync_low", r.low, vecs[i].exp_low);
         chk("vec_gap", gap_a, vecs[i].exp_gap);
         chk("vec_ldac_w", ldac_w_a, vecs[i].exp_ldac);
         chk("vec_done_cnt", done_a - d0, 1);
         chk("vec_sdo_idle", int'(ia.sdo), 0);
      end
      nrec = recs.size();
      ia.in_data = 24'h340000;
      ia.in_valid = 1'b1;
      tick();
      ia.in_data = 24'h3FFF00;
      n = 0;
      while (!ia.in_ready && n < 400) begin tick(); n++; end
      chk("b2b_done_with_ready", int'(ia.done), 1);
      tick();
      ia.in_valid = 1'b0;
      chk("b2b_second_accepted", int'(ia.busy), 1);
      wait_done_a();
      tick();
      chk("b2b_nframes", recs.size() - nrec, 2);
      chk("b2b_frame0", int'(recs[nrec].frame), 24'h340000);
      chk("b2b_frame1", int'(recs[nrec + 1].frame), 24'h3FFF00);
      chk("b2b_falls1", recs[nrec + 1].falls, 24);
      chk("b2b_sync_high", recs[nrec + 1].high_before, 7);
      nrec = recs.size();
      d0 = done_a;
      send_a(24'h3FFF00);
      for (int i = 0; i < 80; i++) begin
         ia.in_data = 24'hFFFFFF;
         ia.in_valid = i[0];
         tick();
      end
      ia.in_valid = 1'b0;
      wait_done_a();
      repeat (20) tick();
      chk("busy_ign_nframes", recs.size() - nrec, 1);
      chk("busy_ign_frame", int'(recs[recs.size() - 1].frame), 24'h3FFF00);
      chk("busy_ign_done_cnt", done_a - d0, 1);
      chk("busy_ign_idle", int'(ia.busy), 0);
      nrec = recs.size();
      d0 = done_a;
      send_a(24'h3ABCDE);
      n = 0;
      while (falls_a < 10 && n < 400) begin tick(); n++; end
      chk("abort_reached_10", falls_a, 10);
      rst = 1'b1;
      tick();
      chk("abort_sync_n", int'(ia.sync_n), 1);
      chk("abort_sclk", int'(ia.sclk), 1);
      chk("abort_ldac_n", int'(ia.ldac_n), 1);
      chk("abort_busy", int'(ia.busy), 0);
      chk("abort_ready", int'(ia.in_ready), 0);
      rst = 1'b0;
      tick();
      chk("abort_ready_after", int'(ia.in_ready), 1);
      repeat (10) tick();
      chk("abort_no_done", done_a - d0, 0);
      chk("abort_no_frame", recs.size() - nrec, 0);
      send_a(24'h38FF00);
      wait_done_a();
      tick();
      chk("post_abort_frame", int'(recs[recs.size() - 1].frame), 24'h38FF00);
      chk("post_abort_falls", recs[recs.size() - 1].falls, 24);
      chk("post_abort_low", recs[recs.size() - 1].low, 98);
      chk("b_ready", int'(ib.in_ready), 1);
      d0 = done_b;
      ib.in_data = 24'hC3A55A;
      ib.in_valid = 1'b1;
      tick();
      ib.in_valid = 1'b0;
      n = 0;
      while (!ib.done && n < 200) begin tick(); n++; end
      chk("b_done_seen", int'(ib.done), 1);
      tick();
      chk("b_frame", int'(frame_b), 24'hC3A55A);
      chk("b_falls", falls_last_b, 24);
      chk("b_sync_low", low_last_b, 49);
      chk("b_period_min", per_min_b, 2);
      chk("b_period_max", per_max_b, 2);
      chk("b_ldac_never_low", ldac_low_b, 0);
      chk("b_done_cnt", done_b - d0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
